program_loader: RTL
===================

// Module: program_loader
// PURPOSE
// Front end that fills the 8-word program Memory from chip pins before the CPU runs.
// A host pulses a strobe with 4-bit nibbles (opcode first, then immediate).
// The block assembles each nibble pair into one write on the Memory write port.
// It holds the CPU in reset while load mode is active and releases it afterwards.
// PARAMETERS
// MAX_MEM      8   words in program Memory; loading stops after MAX_MEM words
// ADDR_W       4   width of Memory address / word counter
// SYNC_STAGES  2   flip-flop stages on every pin input (ld_en, ld_strobe, ld_data)
// PORTS
// clk            in   1       system clock
// rst_n          in   1       asynchronous active-low reset
// ld_en          in   1       async pin; 1 = load mode, 0 = run mode
// ld_strobe      in   1       async pin; each rising edge transfers one nibble
// ld_data        in   4       async pin; nibble, held stable around the strobe edge
// mem_write      out  1       one-cycle write pulse to Memory
// mem_address    out  ADDR_W  Memory address (write address during load)
// mem_opcode     out  4       opcode nibble to Memory
// mem_immediate  out  4       immediate nibble to Memory
// cpu_rst_n      out  1       active-low CPU reset; 0 while loading
// loading        out  1       1 while in any load state
// word_count     out  ADDR_W  words written since load mode entered
// overflow       out  1       sticky; strobe received while FULL
// BEHAVIOUR
// - Reset: every output 0, state RUN_WAIT, all sync flops 0.
// - ld_en, ld_strobe and ld_data each pass through SYNC_STAGES flops. A strobe edge
//   is sync'd strobe 1 while the previous sync'd value was 0. One cycle wide.
// - Nibble capture uses the synchronised ld_data in the edge cycle. Host holds
//   ld_data stable >= SYNC_STAGES+1 clk before and after the strobe rising edge.
// - States:
//   RUN_WAIT: cpu_rst_n=0; after 1 cycle with sync'd ld_en=0 -> RUN, else -> LOAD_OP.
//   RUN: cpu_rst_n=1, loading=0, strobes ignored.
//     sync'd ld_en=1 -> LOAD_OP; word_count<=0, overflow<=0.
//   LOAD_OP: cpu_rst_n=0, loading=1. Strobe edge: mem_opcode<=nibble -> LOAD_IMM.
//   LOAD_IMM: strobe edge: mem_immediate<=nibble -> WRITE.
//   WRITE: mem_write=1 for exactly this cycle, mem_address=word_count.
//     Next cycle word_count+1; then -> FULL if word_count+1==MAX_MEM, else LOAD_OP.
//   FULL: strobe edge sets overflow (sticky until next load entry); no writes.
// - Sync'd ld_en=0 in LOAD_OP/LOAD_IMM/FULL -> RUN on the next cycle.
//   A half word (opcode only) is discarded; cpu_rst_n rises the cycle RUN is entered.
// - ld_en falling during WRITE: the write completes, word_count increments, then RUN.
// - Latency: write pulse 1 clk after the immediate-strobe edge cycle.
//   Pin edge to edge cycle is SYNC_STAGES+1 clk.
// - Outside WRITE, mem_address = word_count in load states and 0 in RUN/RUN_WAIT.
//   mem_write is never 1 outside WRITE.
// - Re-entering load mode restarts at address 0. Old Memory contents beyond the new
//   word_count stay unchanged (Memory itself is cleared only by rst_n).
// - Async reset mid-load: immediately back to reset state; cpu_rst_n=0; no write.
// TESTING
// 1 rst, ld_en=1, pairs (3,A),(5,1) -> writes {addr0,op3,imm A},{addr1,op5,imm1}.
//   word_count=2, cpu_rst_n=0.
// 2 8 full pairs then 9th strobe -> 8 pulses at addr0..7, state FULL, overflow=1.
//   mem_write stays 0 afterwards.
// 3 opcode 7 only, then ld_en=0 -> no mem_write, cpu_rst_n=1 within SYNC_STAGES+2 clk.
// 4 ld_en=0 during WRITE -> pulse still issued, word_count increments, then RUN.
// 5 in RUN, toggle ld_strobe 5 times -> no mem_write, word_count unchanged.
//   Re-entering load clears overflow and word_count.
// 6 rst_n low for 1 clk mid LOAD_IMM -> all outputs 0 at once; next load starts addr0.

Source files
------------

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - host pin and memory write port bundle for the program loader
// slave = loader side, master = host/memory side.
interface program_loader_if #(
  parameter int ADDR_W = 4
);
  logic              ld_en;
  logic              ld_strobe;
  logic [3:0]        ld_data;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_opcode;
  logic [3:0]        mem_immediate;
  logic              cpu_rst_n;
  logic              loading;
  logic [ADDR_W-1:0] word_count;
  logic              overflow;

  modport slave (
    input  ld_en, ld_strobe, ld_data,
    output mem_write, mem_address, mem_opcode, mem_immediate,
    output cpu_rst_n, loading, word_count, overflow
  );

  modport master (
    output ld_en, ld_strobe, ld_data,
    input  mem_write, mem_address, mem_opcode, mem_immediate,
    input  cpu_rst_n, loading, word_count, overflow
  );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - assembles host pin nibble pairs into program memory writes
// Holds the CPU in reset while load mode is active.
module program_loader #(
  parameter int MAX_MEM     = 8,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  program_loader_if.slave io_ld
);
  localparam logic [ADDR_W-1:0] LP_MAX = ADDR_W'(MAX_MEM);

  typedef enum logic [2:0] {
    S_RUN_WAIT, S_RUN, S_LOAD_OP, S_LOAD_IMM, S_WRITE, S_FULL
  } state_t;

  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_en_sync;
  logic [SYNC_STAGES-1:0] r_stb_sync;
  logic [3:0]             r_data_sync [SYNC_STAGES];
  logic                   r_stb_prev;

  logic [3:0]        r_opcode;
  logic [3:0]        r_immediate;
  logic [ADDR_W-1:0] r_word_count;
  logic              r_overflow;

  logic       w_en, w_edge;
  logic [3:0] w_nibble;
  logic       w_cap_op, w_cap_imm, w_clear, w_incr, w_set_ovf;

  // All three pins are asynchronous to clk, so each gets its own synchroniser chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en_sync  <= '0;
      r_stb_sync <= '0;
      r_stb_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= 4'h0;
    end else begin
      r_en_sync      <= {r_en_sync[SYNC_STAGES-2:0], io_ld.ld_en};
      r_stb_sync     <= {r_stb_sync[SYNC_STAGES-2:0], io_ld.ld_strobe};
      r_stb_prev     <= r_stb_sync[SYNC_STAGES-1];
      r_data_sync[0] <= io_ld.ld_data;
      for (int i = 1; i < SYNC_STAGES; i++) r_data_sync[i] <= r_data_sync[i-1];
    end
  end

  assign w_en     = r_en_sync[SYNC_STAGES-1];
  assign w_edge   = r_stb_sync[SYNC_STAGES-1] & ~r_stb_prev;
  assign w_nibble = r_data_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_RUN_WAIT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    w_cap_op          = 1'b0;
    w_cap_imm         = 1'b0;
    w_clear           = 1'b0;
    w_incr            = 1'b0;
    w_set_ovf         = 1'b0;
    io_ld.mem_write   = 1'b0;
    io_ld.cpu_rst_n   = 1'b0;
    io_ld.loading     = 1'b1;
    io_ld.mem_address = r_word_count;
    case (r_state)
      S_RUN_WAIT: begin
        io_ld.loading     = 1'b0;
        io_ld.mem_address = '0;
        w_clear           = w_en;
        w_next            = w_en ? S_LOAD_OP : S_RUN;
      end
      S_RUN: begin
        io_ld.loading     = 1'b0;
        io_ld.cpu_rst_n   = 1'b1;
        io_ld.mem_address = '0;
        if (w_en) begin
          w_clear = 1'b1;
          w_next  = S_LOAD_OP;
        end
      end
      // Leaving load mode wins over a coincident strobe; a half word is dropped.
      S_LOAD_OP: begin
        if (!w_en) w_next = S_RUN;
        else if (w_edge) begin
          w_cap_op = 1'b1;
          w_next   = S_LOAD_IMM;
        end
      end
      S_LOAD_IMM: begin
        if (!w_en) w_next = S_RUN;
        else if (w_edge) begin
          w_cap_imm = 1'b1;
          w_next    = S_WRITE;
        end
      end
      S_WRITE: begin
        io_ld.mem_write = 1'b1;
        w_incr          = 1'b1;
        if (!w_en)                                 w_next = S_RUN;
        else if ((r_word_count + 1'b1) == LP_MAX)  w_next = S_FULL;
        else                                       w_next = S_LOAD_OP;
      end
      S_FULL: begin
        if (!w_en) w_next = S_RUN;
        else if (w_edge) w_set_ovf = 1'b1;
      end
      default: w_next = S_RUN_WAIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_opcode     <= 4'h0;
      r_immediate  <= 4'h0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_cap_op)  r_opcode    <= w_nibble;
      if (w_cap_imm) r_immediate <= w_nibble;
      if (w_clear) begin
        r_word_count <= '0;
        r_overflow   <= 1'b0;
      end else begin
        if (w_incr)    r_word_count <= r_word_count + 1'b1;
        if (w_set_ovf) r_overflow   <= 1'b1;
      end
    end
  end

  assign io_ld.mem_opcode    = r_opcode;
  assign io_ld.mem_immediate = r_immediate;
  assign io_ld.word_count    = r_word_count;
  assign io_ld.overflow      = r_overflow;
endmodule
